// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU command controller: default sizes,
// ALU operation codes and the controller state encoding.
package alu_ctrl_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_NREG  = 8;
  localparam int DEF_AW    = 3;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/alu_ctrl_if.sv
// Command and response handshake bundle between the issue logic (master)
// and the ALU controller (slave).
interface alu_ctrl_if #(
  parameter int WIDTH = 64,
  parameter int AW    = 3
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [AW-1:0]    cmd_rd;
  logic [AW-1:0]    cmd_rs1;
  logic [AW-1:0]    cmd_rs2;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_flag;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_flag
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_flag
  );

endinterface

// File: rtl/alu_regfile.sv
// Architectural register file: two combinational read ports, writeback port
// with priority over the external load port, r0 hardwired to zero.
module alu_regfile
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREG  = DEF_NREG,
  parameter int AW    = DEF_AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             ext_en,
  input  logic [AW-1:0]    ext_addr,
  input  logic [WIDTH-1:0] ext_data
);

  logic [WIDTH-1:0] regs_r [NREG];

  assign rd_data_a = regs_r[rd_addr_a];
  assign rd_data_b = regs_r[rd_addr_b];

  // Register storage; entry 0 is forced to zero so r0 writes are discarded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      regs_r[0] <= {WIDTH{1'b0}};
      for (int i = 1; i < NREG; i++) begin
        if (wb_en && (wb_addr == AW'(i))) begin
          regs_r[i] <= wb_data;
        end else if (ext_en && (ext_addr == AW'(i))) begin
          regs_r[i] <= ext_data;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
    end
  end

endmodule

// File: rtl/alu_ctrl.sv
// ALU command controller: accepts a command, drives the external ALU for one
// cycle, writes the result back and holds the response until it is taken.
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREG  = DEF_NREG,
  parameter int AW    = DEF_AW
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_ctrl_if.slave        bus,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [1:0]       alu_operation,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_flag
);

  state_e           state_r;
  state_e           next_state_s;
  logic [AW-1:0]    rd_r;
  logic             cmd_ready_r;
  logic             rsp_valid_r;
  logic [WIDTH-1:0] rsp_data_r;
  logic             rsp_flag_r;
  logic [WIDTH-1:0] rs1_data_s;
  logic [WIDTH-1:0] rs2_data_s;
  logic             accept_s;
  logic             wb_en_s;

  assign accept_s      = (state_r == IDLE) && bus.cmd_valid;
  assign wb_en_s       = (state_r == EXEC);
  assign bus.cmd_ready = cmd_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.rsp_flag  = rsp_flag_r;

  alu_regfile #(
    .WIDTH (WIDTH),
    .NREG  (NREG),
    .AW    (AW)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (bus.cmd_rs1),
    .rd_data_a (rs1_data_s),
    .rd_addr_b (bus.cmd_rs2),
    .rd_data_b (rs2_data_s),
    .wb_en     (wb_en_s),
    .wb_addr   (rd_r),
    .wb_data   (alu_out),
    .ext_en    (wr_en),
    .ext_addr  (wr_addr),
    .ext_data  (wr_data)
  );

  // Next-state decode of the IDLE/EXEC/RESP sequence.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.cmd_valid) next_state_s = EXEC;
        else               next_state_s = IDLE;
      end
      EXEC: next_state_s = RESP;
      RESP: begin
        if (bus.rsp_ready) next_state_s = IDLE;
        else               next_state_s = RESP;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State, handshake flags, ALU operand and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      rd_r          <= {AW{1'b0}};
      cmd_ready_r   <= 1'b1;
      rsp_valid_r   <= 1'b0;
      rsp_data_r    <= {WIDTH{1'b0}};
      rsp_flag_r    <= 1'b0;
      alu_operation <= 2'b00;
      alu_a         <= {WIDTH{1'b0}};
      alu_b         <= {WIDTH{1'b0}};
    end else begin
      state_r     <= next_state_s;
      cmd_ready_r <= (next_state_s == IDLE);
      rsp_valid_r <= (next_state_s == RESP);
      if (accept_s) begin
        alu_operation <= bus.cmd_op;
        alu_a         <= rs1_data_s;
        alu_b         <= rs2_data_s;
        rd_r          <= bus.cmd_rd;
      end
      if (state_r == EXEC) begin
        rsp_data_r <= alu_out;
        rsp_flag_r <= alu_flag;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed self-checking bench for alu_ctrl with a behavioural 64-bit ALU
// (carry out for add, borrow for subtract, flag 0 for and/xor).
module tb_alu_ctrl;
  import alu_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [63:0] wr_data;
  logic [1:0]  alu_operation;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [63:0] alu_out;
  logic        alu_flag;
  int          total;
  int          bad;

  alu_ctrl_if #(.WIDTH(64), .AW(3)) bus ();

  alu_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .alu_operation (alu_operation),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_out       (alu_out),
    .alu_flag      (alu_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    alu_out  = 64'd0;
    alu_flag = 1'b0;
    case (alu_operation)
      OP_ADD:  {alu_flag, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      OP_SUB:  {alu_flag, alu_out} = {1'b0, alu_a} - {1'b0, alu_b};
      OP_AND:  alu_out = alu_a & alu_b;
      OP_XOR:  alu_out = alu_a ^ alu_b;
      default: alu_out = 64'd0;
    endcase
  end

  task automatic load_reg(input logic [2:0] addr, input logic [63:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, output logic [63:0] data, output logic flag,
                         output int lat);
    lat = -1; data = 64'd0; flag = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_rd = rd;
    bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (bus.rsp_valid) begin
        lat = i; data = bus.rsp_data; flag = bus.rsp_flag;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%0b exp=1", bus.cmd_ready); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%0b exp=0", bus.rsp_valid); end
    total++; if (bus.rsp_data !== 64'd0) begin bad++; $display("FAIL reset_rsp_data got=%0h exp=0", bus.rsp_data); end
    total++; if ({alu_operation, alu_a, alu_b} !== 130'd0) begin bad++; $display("FAIL reset_alu_outs op=%0h a=%0h b=%0h exp=0", alu_operation, alu_a, alu_b); end
  endtask

  task automatic test_add_dependent;
    logic [63:0] d; logic f; int lat;
    load_reg(3'd1, 64'd5);
    load_reg(3'd2, 64'd3);
    run_cmd(OP_ADD, 3'd3, 3'd1, 3'd2, d, f, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL add_latency got=%0d exp=2", lat); end
    total++; if (d !== 64'd8) begin bad++; $display("FAIL add_data got=%0h exp=8", d); end
    total++; if (f !== 1'b0) begin bad++; $display("FAIL add_flag got=%0b exp=0", f); end
    run_cmd(OP_ADD, 3'd4, 3'd3, 3'd0, d, f, lat);
    total++; if (d !== 64'd8 || lat !== 2) begin bad++; $display("FAIL dependent_add got=%0h lat=%0d exp=8 lat=2", d, lat); end
    run_cmd(OP_SUB, 3'd0, 3'd1, 3'd2, d, f, lat);
    total++; if (d !== 64'd2 || f !== 1'b0) begin bad++; $display("FAIL sub_data got=%0h/%0b exp=2/0", d, f); end
  endtask

  task automatic test_carry;
    logic [63:0] d; logic f; int lat;
    load_reg(3'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    load_reg(3'd2, 64'd1);
    run_cmd(OP_ADD, 3'd5, 3'd1, 3'd2, d, f, lat);
    total++; if (d !== 64'd0) begin bad++; $display("FAIL carry_data got=%0h exp=0", d); end
    total++; if (f !== 1'b1) begin bad++; $display("FAIL carry_flag got=%0b exp=1", f); end
    run_cmd(OP_ADD, 3'd0, 3'd5, 3'd0, d, f, lat);
    total++; if (d !== 64'd0) begin bad++; $display("FAIL carry_r5 got=%0h exp=0", d); end
    run_cmd(OP_AND, 3'd0, 3'd1, 3'd2, d, f, lat);
    total++; if (d !== 64'd1 || f !== 1'b0) begin bad++; $display("FAIL and_data got=%0h/%0b exp=1/0", d, f); end
  endtask

  task automatic test_xor_r0;
    logic [63:0] d; logic f; int lat;
    load_reg(3'd1, 64'hF0);
    load_reg(3'd2, 64'hFF);
    load_reg(3'd0, 64'h1234);
    run_cmd(OP_XOR, 3'd0, 3'd1, 3'd2, d, f, lat);
    total++; if (d !== 64'h0F || f !== 1'b0) begin bad++; $display("FAIL xor_data got=%0h/%0b exp=f/0", d, f); end
    run_cmd(OP_ADD, 3'd0, 3'd0, 3'd0, d, f, lat);
    total++; if (d !== 64'd0) begin bad++; $display("FAIL r0_zero got=%0h exp=0", d); end
  endtask

  task automatic test_stall;
    logic [63:0] d; logic f; int lat;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_XOR; bus.cmd_rd = 3'd0;
    bus.cmd_rs1 = 3'd1; bus.cmd_rs2 = 3'd2;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 64'h0F || bus.cmd_ready !== 1'b0 ||
          alu_a !== 64'hF0 || alu_b !== 64'hFF || alu_operation !== OP_XOR) begin
        bad++;
        $display("FAIL stall_hold cyc=%0d got v=%0b d=%0h rdy=%0b a=%0h b=%0h op=%0h exp v=1 d=f rdy=0 a=f0 b=ff op=3",
                 i, bus.rsp_valid, bus.rsp_data, bus.cmd_ready, alu_a, alu_b, alu_operation);
      end
      bus.cmd_valid = i[0]; bus.cmd_op = OP_ADD; bus.cmd_rd = 3'd7;
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL stall_release got rdy=%0b v=%0b exp rdy=1 v=0", bus.cmd_ready, bus.rsp_valid); end
    run_cmd(OP_ADD, 3'd0, 3'd7, 3'd0, d, f, lat);
    total++; if (d !== 64'd0) begin bad++; $display("FAIL stall_ignored_cmd r7 got=%0h exp=0", d); end
  endtask

  task automatic test_write_priority;
    logic [63:0] d; logic f; int lat;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_ADD; bus.cmd_rd = 3'd6;
    bus.cmd_rs1 = 3'd1; bus.cmd_rs2 = 3'd2;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 64'hDEAD;
    @(negedge clk);
    wr_en = 1'b0;
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 64'h1EF) begin bad++; $display("FAIL wb_rsp got v=%0b d=%0h exp v=1 d=1ef", bus.rsp_valid, bus.rsp_data); end
    run_cmd(OP_ADD, 3'd0, 3'd6, 3'd0, d, f, lat);
    total++; if (d !== 64'h1EF) begin bad++; $display("FAIL wb_over_ext got=%0h exp=1ef", d); end
    // external load in IDLE, read by a command accepted on the very next edge
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 64'h1234;
    @(negedge clk);
    wr_en = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_ADD; bus.cmd_rd = 3'd0;
    bus.cmd_rs1 = 3'd6; bus.cmd_rs2 = 3'd0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 64'h1234) begin bad++; $display("FAIL ext_write_next got v=%0b d=%0h exp v=1 d=1234", bus.rsp_valid, bus.rsp_data); end
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 64'h5555;
    bus.cmd_valid = 1'b1; bus.cmd_rs1 = 3'd6;
    @(negedge clk);
    wr_en = 1'b0; bus.cmd_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.rsp_data !== 64'h1234) begin bad++; $display("FAIL same_cycle_prewrite got=%0h exp=1234", bus.rsp_data); end
    run_cmd(OP_ADD, 3'd0, 3'd6, 3'd0, d, f, lat);
    total++; if (d !== 64'h5555) begin bad++; $display("FAIL same_cycle_write got=%0h exp=5555", d); end
  endtask

  task automatic test_reset_exec;
    logic [63:0] d; logic f; int lat;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_ADD; bus.cmd_rd = 3'd7;
    bus.cmd_rs1 = 3'd1; bus.cmd_rs2 = 3'd2;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++; if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_exec_hs got rdy=%0b v=%0b exp rdy=1 v=0", bus.cmd_ready, bus.rsp_valid); end
    total++; if (bus.rsp_data !== 64'd0 || bus.rsp_flag !== 1'b0 || alu_a !== 64'd0 || alu_b !== 64'd0 || alu_operation !== 2'b00) begin
      bad++; $display("FAIL rst_exec_outs got d=%0h f=%0b a=%0h b=%0h op=%0h exp 0", bus.rsp_data, bus.rsp_flag, alu_a, alu_b, alu_operation);
    end
    run_cmd(OP_ADD, 3'd0, 3'd7, 3'd0, d, f, lat);
    total++; if (d !== 64'd0) begin bad++; $display("FAIL rst_exec_r7 got=%0h exp=0", d); end
    run_cmd(OP_ADD, 3'd0, 3'd1, 3'd0, d, f, lat);
    total++; if (d !== 64'd0) begin bad++; $display("FAIL rst_exec_r1 got=%0h exp=0", d); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 64'd0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_rd = 3'd0;
    bus.cmd_rs1 = 3'd0; bus.cmd_rs2 = 3'd0; bus.rsp_ready = 1'b1;
    test_reset;
    test_add_dependent;
    test_carry;
    test_xor_r0;
    test_stall;
    test_write_priority;
    test_reset_exec;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
